// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner with a small write-addressed digit memory.
// Optional anti-ghosting blank at the start of each slot is enabled by defining SCAN_GUARD_EN.
module seg_scan_driver #(
  parameter int PRESCALE = 100000,
  parameter int GUARD    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       W,
  input  logic [2:0] WADD,
  input  logic [5:0] DIN,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  // Elaboration-time rejection of illegal parameter combinations.
  if (PRESCALE < 4 || PRESCALE > (1 << 20)) begin : g_bad_prescale
    $error("seg_scan_driver: PRESCALE out of range");
  end
  if (GUARD < 1 || GUARD > PRESCALE - 2) begin : g_bad_guard
    $error("seg_scan_driver: GUARD out of range");
  end

  logic [CW-1:0] cnt_reg;
  logic [2:0]    idx_reg;
  logic [5:0]    mem_reg [8];
  logic          slot_wrap;
  logic          guard_phase;
  logic [5:0]    cur_word;
  logic [6:0]    hex_seg;
  logic [7:0]    an_reg,  an_next;
  logic [6:0]    seg_reg, seg_next;
  logic          dp_reg,  dp_next;
  logic          fd_reg,  fd_next;

  assign slot_wrap = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else if (slot_wrap) begin
      cnt_reg <= '0;
      idx_reg <= idx_reg + 3'd1;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // One register per digit so writes and scanning never contend.
  for (genvar gi = 0; gi < 8; gi++) begin : g_mem
    always_ff @(posedge clk) begin
      if (reset) begin
        mem_reg[gi] <= '0;
      end else if (W && (WADD == 3'(gi))) begin
        mem_reg[gi] <= DIN;
      end
    end
  end

  assign cur_word = mem_reg[idx_reg];

`ifdef SCAN_GUARD_EN
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
  assign guard_phase = (cnt_reg < GUARD_C);
`else
  assign guard_phase = 1'b0;
`endif

  // Active-low hex font, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    hex_seg = 7'h7F;
    case (cur_word[4:1])
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      4'hF: hex_seg = 7'b0001110;
      default: hex_seg = 7'h7F;
    endcase
  end

  always_comb begin
    an_next  = 8'hFF;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    fd_next  = slot_wrap && (idx_reg == 3'd7);
    if (!guard_phase && cur_word[5]) begin
      an_next  = ~(8'b1 << idx_reg);
      seg_next = hex_seg;
      dp_next  = cur_word[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_reg  <= 8'hFF;
      seg_reg <= 7'h7F;
      dp_reg  <= 1'b1;
      fd_reg  <= 1'b0;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
      fd_reg  <= fd_next;
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign frame_done = fd_reg;

endmodule
